// File: rtl/sram_req_arbiter_if.sv
// Sram-like request channel: req/addr_ok request handshake, data_ok response.
// master drives the request fields; slave answers with addr_ok/data_ok/rdata.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-master (inst read-only, data read/write) to one-slave sram-like arbiter.
// Zero-cycle accept path; an in-order tag FIFO routes each response back to
// the master that issued the request.
module sram_req_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               reset,
    sram_req_arbiter_if.slave  inst_sram,
    sram_req_arbiter_if.slave  data_sram,
    sram_req_arbiter_if.master mem
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    // Lock state: a request offered but not yet accepted keeps the port.
    logic        lock_q;
    logic        lock_owner_q;          // 1 = data, 0 = inst
    logic        lk_wr_q;
    logic [1:0]  lk_size_q;
    logic [3:0]  lk_wstrb_q;
    logic [31:0] lk_addr_q;
    logic [31:0] lk_wdata_q;

    // Tag FIFO of accepted-but-unanswered requests.
    logic [OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;

    logic        owner;
    logic        full;
    logic        req;
    logic        push;
    logic        pop;
    logic        head;
    logic        live_wr;
    logic [1:0]  live_size;
    logic [3:0]  live_wstrb;
    logic [31:0] live_addr;
    logic [31:0] live_wdata;

    // Owner selection, grant, downstream field mux and ack/response routing.
    always_comb begin
        owner = lock_q ? lock_owner_q : data_sram.req;
        full  = (count_q == CW'(OUTSTANDING));
        req   = ~full & (owner ? data_sram.req : inst_sram.req);
        push  = req & mem.addr_ok;
        pop   = mem.data_ok & (count_q != '0);
        head  = tag_q[rd_ptr_q];

        // Inst channel is read-only: write-side fields are forced to zero.
        live_wr    = 1'b0;
        live_size  = inst_sram.size;
        live_wstrb = 4'b0;
        live_addr  = inst_sram.addr;
        live_wdata = 32'b0;
        if (owner) begin
            live_wr    = data_sram.wr;
            live_size  = data_sram.size;
            live_wstrb = data_sram.wstrb;
            live_addr  = data_sram.addr;
            live_wdata = data_sram.wdata;
        end

        mem.req   = req;
        // Fields come from the lock snapshot while waiting, so nothing can
        // shift under a pending request; all fields idle at zero without req.
        mem.wr    = req & (lock_q ? lk_wr_q : live_wr);
        mem.size  = req ? (lock_q ? lk_size_q  : live_size)  : 2'b0;
        mem.wstrb = req ? (lock_q ? lk_wstrb_q : live_wstrb) : 4'b0;
        mem.addr  = req ? (lock_q ? lk_addr_q  : live_addr)  : 32'b0;
        mem.wdata = req ? (lock_q ? lk_wdata_q : live_wdata) : 32'b0;

        inst_sram.addr_ok = push & ~owner;
        data_sram.addr_ok = push & owner;
        inst_sram.data_ok = pop & ~head;
        data_sram.data_ok = pop & head;
        inst_sram.rdata   = mem.rdata;
        data_sram.rdata   = mem.rdata;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Lock set on an unaccepted offer, cleared on acceptance; snapshot fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            lk_wr_q      <= 1'b0;
            lk_size_q    <= 2'b0;
            lk_wstrb_q   <= 4'b0;
            lk_addr_q    <= 32'b0;
            lk_wdata_q   <= 32'b0;
        end else if (req & mem.addr_ok) begin
            lock_q <= 1'b0;
        end else if (req & ~lock_q) begin
            lock_q       <= 1'b1;
            lock_owner_q <= owner;
            lk_wr_q      <= live_wr;
            lk_size_q    <= live_size;
            lk_wstrb_q   <= live_wstrb;
            lk_addr_q    <= live_addr;
            lk_wdata_q   <= live_wdata;
        end
    end

    // Tag FIFO: push owner on acceptance, pop on each valid response.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= owner;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-master, one-slave arbiter for sram-like memory requests. It merges the IF-stage instruction channel (read-only) and the EXE-stage data channel (read/write, including cacop-free loads/stores) onto a single sram-like port toward the bus bridge. It preserves the req/addr_ok/data_ok handshake on every side and returns each in-order response to the master that issued it.

## Interface
- OUTSTANDING, 4, maximum accepted-but-unanswered requests; power of two, ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req  in  1  instruction read request; held until inst_sram_addr_ok
- inst_sram_size  in  2  0=byte, 1=half, 2=word
- inst_sram_addr  in  32  physical address
- inst_sram_addr_ok  out  1  instruction request accepted this cycle
- inst_sram_data_ok  out  1  instruction response valid this cycle
- inst_sram_rdata  out  32  instruction read data
- data_sram_req  in  1  data request; held until data_sram_addr_ok
- data_sram_wr  in  1  1=write, 0=read
- data_sram_size  in  2  0=byte, 1=half, 2=word
- data_sram_wstrb  in  4  byte strobes (writes)
- data_sram_addr  in  32  physical address
- data_sram_wdata  in  32  write data
- data_sram_addr_ok  out  1  data request accepted this cycle
- data_sram_data_ok  out  1  data response (read data or write completion) valid
- data_sram_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accepted mem_req this cycle
- mem_data_ok  in  1  downstream response valid (strictly in acceptance order)
- mem_rdata  in  32  downstream read data

## Operation
- Owner selection: if lock_valid, owner = lock_owner. Otherwise data wins over inst when both request, because the data request is older in program order. Inst may starve while data requests back-to-back; this is accepted.
- Grant is blocked while count == OUTSTANDING. This holds even if mem_data_ok pops in the same cycle.
- mem_req = grant & (selected master's req).
- mem_wr/size/wstrb/addr/wdata are muxed from the owner. For inst, mem_wr = 0, mem_wstrb = 0, mem_wdata = 0.
- Ack routing: x_addr_ok = mem_req & mem_addr_ok & (owner == x). The non-owner's addr_ok is 0.
- Lock: set on mem_req & ~mem_addr_ok, recording the owner. Cleared on mem_addr_ok. While locked, owner and all mem_* fields stay frozen, so a higher-priority request arriving mid-wait cannot preempt.
- Tag FIFO: OUTSTANDING entries, 1 bit each (0=inst, 1=data).
  - Push on mem_req & mem_addr_ok.
  - Pop on mem_data_ok & count != 0.
  - Pointers wrap modulo OUTSTANDING; count is clog2(OUTSTANDING)+1 bits.
- Response routing: inst_sram_data_ok = mem_data_ok & count != 0 & head == 0. data_sram_data_ok is the same with head == 1.
- inst_sram_rdata = data_sram_rdata = mem_rdata, unqualified; masters sample only on their data_ok.
- mem_data_ok with count == 0 is ignored: no pop, no data_ok to either master.

## Timing
- Reset: count = 0, pointers = 0, lock_valid = 0. With both reqs low, every output is 0.
- Accept latency: zero cycles. mem_req follows upstream req combinationally, and addr_ok returns in the same cycle as mem_addr_ok.
- Back-to-back acceptance on consecutive cycles is allowed until full.
- A response never belongs to a request accepted in the same cycle; downstream latency is ≥1 cycle.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Full: first grant possible in the cycle after the pop that takes count below OUTSTANDING.
- Reset mid-operation: FIFO and lock are cleared. Late responses after reset hit count == 0 and are dropped.

## Test plan
- Single inst read, addr 0x1c000000, mem_addr_ok at cycle 0, mem_data_ok at cycle 2 with rdata 0x02800000 -> inst_sram_addr_ok=1 at cycle 0; inst_sram_data_ok=1 with rdata 0x02800000 at cycle 2; data_sram_data_ok=0 throughout.
- Inst and data reqs both high at cycle 0, mem_addr_ok held 1 -> data accepted at cycle 0, inst at cycle 1. Two responses then go first to data_sram_data_ok, then to inst_sram_data_ok.
- Inst req at cycle 0 with mem_addr_ok=0 for cycles 0–2 and 1 at cycle 3; data req rises at cycle 1 -> mem_addr = inst addr and mem_wr = 0 through cycle 3; data accepted at cycle 4.
- OUTSTANDING=4: four reads accepted with no response -> mem_req=0 on the fifth request. mem_data_ok at cycle t -> mem_req=1 at t+1.
- Data write: addr 0x00000100, wstrb 0011, wdata 0x0000BEEF -> mem_wr=1, mem_wstrb=0011, mem_wdata=0x0000BEEF. The write's mem_data_ok yields data_sram_data_ok=1 only.
- Reset with 2 outstanding, then mem_data_ok pulse -> no data_ok to either master; the next inst request is accepted normally.
